// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the multiplexed digit scanner
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
    function automatic logic [NUM_DIGITS-1:0] idx_to_onehot(input logic [1:0] idx);
        return {1'b1, {(NUM_DIGITS-1){1'b0}}} >> idx;
    endfunction
endpackage

// File: rtl/seg_pwm_gate.sv
// seg_pwm_gate: slot counter with brightness latch and PWM gate for the next cycle
module seg_pwm_gate #(
    parameter int DWELL_CYCLES = 4096,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             restart,
    input  logic             on_next,
    input  logic [3:0]       brightness,
    output logic [CNT_W-1:0] cnt,
    output logic             gate_next
);
    localparam int K = $clog2(DWELL_CYCLES) - 4;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0] bright_q, bright_d;
    // brightness is latched as each ON slot begins so a slot never changes duty midway
    always_comb begin
        cnt_d = restart ? '0 : cnt + 1'b1;
        bright_d = (restart && on_next) ? brightness : bright_q;
        gate_next = on_next && ((cnt_d >> K) <= CNT_W'(bright_d));
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
            bright_q <= '0;
        end else begin
            cnt <= cnt_d;
            bright_q <= bright_d;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit display scanner with blanking, PWM dimming and frame-atomic updates
module seg_scan_ctrl import seg_pkg::*; #(
    parameter int DWELL_CYCLES = 4096,
    parameter int BLANK_CYCLES = 64,
    parameter int CNT_W = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dots,
    input  logic [3:0]  brightness,
    output logic [3:0]  nibble,
    output logic        dot,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_en,
    output logic        frame_tick
);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_PRE = CNT_W'(DWELL_CYCLES - 2);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam state_t FIRST = (BLANK_CYCLES > 0) ? BLANK : ON;
    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt;
    logic expire, restart, gate_next, tick_d, xfer, apply;
    logic [15:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [3:0] act_dots_q, act_dots_d, pend_dots_q, pend_dots_d;
    logic pend_full_q, pend_full_d;
    seg_pwm_gate #(.DWELL_CYCLES(DWELL_CYCLES), .CNT_W(CNT_W)) u_gate (
        .CLK(CLK),
        .RST_N(RST_N),
        .restart(restart),
        .on_next(state_d == ON),
        .brightness(brightness),
        .cnt(cnt),
        .gate_next(gate_next)
    );
    // outputs are registered from next-state values so they line up with the state they describe
    always_comb begin
        expire = (state_q == BLANK && cnt == B_LAST) || (state_q == ON && cnt == D_LAST);
        state_d = !enable ? IDLE : state_q == IDLE ? FIRST : !expire ? state_q : state_q == BLANK ? ON : FIRST;
        idx_d = !enable ? 2'd0 : (expire && state_q == ON) ? idx_q + 2'd1 : idx_q;
        restart = !enable || state_q == IDLE || expire;
        tick_d = enable && state_q == ON && idx_q == 2'd3 && cnt == D_PRE;
        xfer = upd_valid && upd_ready;
        apply = pend_full_q && (frame_tick || state_q == IDLE);
        pend_full_d = apply ? 1'b0 : xfer ? 1'b1 : pend_full_q;
        pend_val_d = xfer ? upd_value : pend_val_q;
        pend_dots_d = xfer ? upd_dots : pend_dots_q;
        act_val_d = apply ? pend_val_q : act_val_q;
        act_dots_d = apply ? pend_dots_q : act_dots_q;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q <= '0;
            pend_full_q <= 1'b0;
            pend_val_q <= '0;
            pend_dots_q <= '0;
            act_val_q <= '0;
            act_dots_q <= '0;
            upd_ready <= 1'b0;
            nibble <= '0;
            dot <= 1'b0;
            digit_sel <= '0;
            digit_en <= '0;
            frame_tick <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            pend_full_q <= pend_full_d;
            pend_val_q <= pend_val_d;
            pend_dots_q <= pend_dots_d;
            act_val_q <= act_val_d;
            act_dots_q <= act_dots_d;
            upd_ready <= !pend_full_d;
            nibble <= 4'(act_val_d >> {~idx_d, 2'b00});
            dot <= act_dots_d[idx_d];
            digit_sel <= idx_d;
            digit_en <= gate_next ? idx_to_onehot(idx_d) : 4'd0;
            frame_tick <= tick_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboarded directed bench for the digit scanner
module tb_seg_scan_ctrl;
    logic CLK = 0, RST_N = 0, enable = 0, upd_valid = 0;
    logic [15:0] upd_value = '0;
    logic [3:0] upd_dots = '0, brightness = 4'd15;
    logic upd_ready, dot, frame_tick;
    logic [3:0] nibble, digit_en;
    logic [1:0] digit_sel;
    int n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];
    bit mon_on = 0;
    bit in_slot = 0, s_flag = 0;
    logic [31:0] s_word;
    int s_len = 0;
    int n;
    bit seen;

    always #5 CLK = ~CLK;

    seg_scan_ctrl #(.DWELL_CYCLES(16), .BLANK_CYCLES(2), .CNT_W(8)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .enable(enable),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_value(upd_value),
        .upd_dots(upd_dots),
        .brightness(brightness),
        .nibble(nibble),
        .dot(dot),
        .digit_sel(digit_sel),
        .digit_en(digit_en),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endtask

    // slot record: {sel, digit_en, nibble, dot, on_length}
    function automatic logic [31:0] slot_exp(input int sel, input logic [15:0] v, input logic [3:0] d, input int len);
        logic [1:0] s = 2'(sel);
        logic [3:0] en = 4'b1000 >> s;
        logic [3:0] nib = 4'(v >> (4 * (3 - sel)));
        return {13'd0, s, en, nib, d[s], 8'(len)};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int len, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(slot_exp(i, v, d, len));
    endtask

    task automatic wait_tick();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge CLK);
            got = frame_tick;
        end
        chk("tick_seen", 32'(got), 32'd1);
    endtask

    task automatic blank_then_on(input string nm, input logic [3:0] exp_nib);
        int z = 0;
        bit on = 0;
        for (int i = 0; i < 10 && !on; i++) begin
            @(negedge CLK);
            if (digit_en == 4'd0) z++;
            else on = 1;
        end
        chk({nm, "_blank_len"}, 32'(z), 32'd2);
        chk({nm, "_first_on"}, {22'd0, digit_sel, digit_en, nibble}, {22'd0, 2'd0, 4'b1000, exp_nib});
    endtask

    always @(negedge CLK) begin
        if (digit_en != 4'd0) begin
            if (!in_slot) begin
                in_slot = 1;
                s_flag = mon_on;
                s_len = 0;
                s_word = {13'd0, digit_sel, digit_en, nibble, dot, 8'd0};
            end
            s_len++;
        end else if (in_slot) begin
            in_slot = 0;
            if (s_flag) begin
                if (exp_q.size() == 0) chk("slot_unexpected", s_word | 32'(s_len), 32'd0);
                else chk("slot", s_word | 32'(s_len), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by 200000 ns");
        $fatal(1);
    end

    initial begin
        push_frame(16'h0000, 4'b0000, 16, 4);
        push_frame(16'h0000, 4'b0000, 16, 4);
        push_frame(16'h0000, 4'b0000, 16, 4);
        push_frame(16'h1234, 4'b0010, 16, 4);
        push_frame(16'h1234, 4'b0010, 1, 4);
        push_frame(16'h1234, 4'b0010, 8, 4);
        push_frame(16'h1234, 4'b0010, 16, 4);
        push_frame(16'hA5C3, 4'b1001, 16, 4);
        push_frame(16'h0F1E, 4'b0110, 16, 2);
        repeat (3) @(negedge CLK);
        chk("reset_outs", {22'd0, digit_en, nibble, dot, digit_sel, frame_tick, upd_ready}, 32'd0);
        RST_N = 1;
        @(negedge CLK);
        chk("ready_after_reset", 32'(upd_ready), 32'd1);
        mon_on = 1;
        enable = 1;
        blank_then_on("start", 4'h0);
        wait_tick();
        n = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            n++;
            seen = frame_tick;
        end
        chk("frame_period", 32'(n), 32'd72);
        repeat (20) @(negedge CLK);
        chk("ready_before_upd", 32'(upd_ready), 32'd1);
        upd_valid = 1;
        upd_value = 16'h1234;
        upd_dots = 4'b0010;
        @(negedge CLK);
        upd_valid = 0;
        chk("ready_falls", 32'(upd_ready), 32'd0);
        wait_tick();
        chk("ready_on_tick", 32'(upd_ready), 32'd0);
        @(negedge CLK);
        chk("ready_after_tick", 32'(upd_ready), 32'd1);
        wait_tick();
        brightness = 4'd0;
        wait_tick();
        brightness = 4'd7;
        wait_tick();
        brightness = 4'd15;
        repeat (10) @(negedge CLK);
        chk("ready_a", 32'(upd_ready), 32'd1);
        upd_valid = 1;
        upd_value = 16'hA5C3;
        upd_dots = 4'b1001;
        @(negedge CLK);
        chk("held_ready_low", 32'(upd_ready), 32'd0);
        upd_value = 16'h0F1E;
        upd_dots = 4'b0110;
        wait_tick();
        chk("held_ready_tick", 32'(upd_ready), 32'd0);
        @(negedge CLK);
        chk("ready_b", 32'(upd_ready), 32'd1);
        chk("applied_a", 32'(nibble), 32'hA);
        @(negedge CLK);
        chk("b_captured", 32'(upd_ready), 32'd0);
        upd_valid = 0;
        wait_tick();
        repeat (30) @(negedge CLK);
        mon_on = 0;
        repeat (15) @(negedge CLK);
        chk("dig2_on", {26'd0, digit_sel, digit_en}, {26'd0, 2'd2, 4'b0010});
        enable = 0;
        @(negedge CLK);
        chk("dark_next", {26'd0, digit_en, digit_sel}, 32'd0);
        n = 0;
        repeat (80) begin
            @(negedge CLK);
            n += int'(frame_tick);
        end
        chk("no_tick_idle", 32'(n), 32'd0);
        chk("ready_idle", 32'(upd_ready), 32'd1);
        upd_valid = 1;
        upd_value = 16'hBEEF;
        upd_dots = 4'b0101;
        @(negedge CLK);
        upd_valid = 0;
        chk("idle_ready_low", 32'(upd_ready), 32'd0);
        @(negedge CLK);
        chk("idle_applied", {26'd0, nibble, dot, upd_ready}, {26'd0, 4'hB, 1'b1, 1'b1});
        push_frame(16'hBEEF, 4'b0101, 16, 4);
        mon_on = 1;
        enable = 1;
        blank_then_on("restart", 4'hB);
        wait_tick();
        mon_on = 0;
        repeat (30) @(negedge CLK);
        RST_N = 0;
        @(negedge CLK);
        chk("reset_mid", {22'd0, digit_en, nibble, dot, digit_sel, frame_tick, upd_ready}, 32'd0);
        RST_N = 1;
        blank_then_on("post_reset", 4'h0);
        chk("post_reset_ready", 32'(upd_ready), 32'd1);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
